piso_frame_tx: RTL and testbench
================================

# piso_frame_tx

Parallel-in serial-out framed transmitter that sits directly downstream of the 8-bit parallel register stage. It accepts the register's 8-bit parallel output through a valid/ready handshake and transmits it serially, LSB first. Each frame carries a start bit, 8 data bits, an optional even-parity bit and a stop bit. Each bit is held for a programmable number of clock cycles.

## Interface

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..255.
- PARITY_EN, default 0: 1 inserts an even-parity bit after data bit 7; 0 omits it.

Ports:
- CLK, input, 1: single clock; all state updates on the posedge.
- RSTN, input, 1: reset is synchronous and active-low.
- Din, input, 8: parallel byte from the upstream register (its Dout).
- DVALID, input, 1: Din is valid.
- DREADY, output, 1: block can accept a byte.
- SOUT, output, 1: serial line; idles high.
- BUSY, output, 1: a frame is in progress.
- DONE, output, 1: one-cycle pulse at frame end.

## Operation

- Reset values (first posedge with RSTN=0):
  - state = IDLE
  - SOUT = 1, BUSY = 0, DONE = 0
  - bit timer = 0, bit index = 0
- DREADY:
  - DREADY = RSTN && (state == IDLE); this is combinational from registered state.
  - DREADY is 0 while RSTN is low.
- States:
  - IDLE: SOUT = 1. On posedge with DVALID && DREADY:
    - capture Din into an 8-bit shift register;
    - capture even parity (XOR of Din) if PARITY_EN;
    - go to START.
  - START: SOUT = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: SOUT = shreg[0]. Every CLKS_PER_BIT cycles:
    - shift the register right;
    - increment the bit index.
    - After bit 7 completes, go to PARITY (if PARITY_EN) or STOP.
  - PARITY: SOUT = captured parity for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: SOUT = 1 for CLKS_PER_BIT cycles, then go to IDLE and pulse DONE.
- BUSY = 1 in every state except IDLE.
- Din and DVALID are ignored outside IDLE. The producer must hold DVALID and Din until it sees DREADY.
- Bit timer:
  - counts 0..CLKS_PER_BIT-1;
  - a tick fires when the count equals CLKS_PER_BIT-1;
  - the count resets to 0 on every state change.
  - With CLKS_PER_BIT = 1, every cycle is a tick.
- The bit index is 3 bits. It wraps 7→0 on the last DATA tick, so it is 0 again at the start of the next frame.
- Reset mid-frame: the next posedge with RSTN=0 aborts the frame immediately. All registers take reset values, SOUT returns to 1, and DONE is not pulsed.
- DVALID asserted during the reset cycle is not accepted.

## Timing

- SOUT is registered. If the handshake happens at edge T, SOUT is 0 from edge T onward, in the cycle after T.
- Frame length is N × CLKS_PER_BIT cycles, where N = 10 (PARITY_EN=0) or 11 (PARITY_EN=1).
- The state returns to IDLE at edge T + N×CLKS_PER_BIT.
  - DONE is high for exactly that one IDLE cycle.
  - BUSY falls at the same edge.
  - DREADY rises at the same edge.
- Maximum throughput is one byte per N×CLKS_PER_BIT + 1 cycles. A byte can be accepted in the DONE cycle.
- Handshake and DONE occurring in the same cycle is legal. The new frame's start bit follows directly, and DONE still pulses for one cycle only.

## Structure

- Shared package piso_pkg:
  - state typedef tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constant DATA_BITS = 8;
  - constant SOUT_IDLE = 1'b1.
- One sub-module, bit_tick_gen (parameter CLKS_PER_BIT). It contains:
  - the bit-timer counter;
  - a clear input, driven on state change;
  - a tick output.
- The top level holds the FSM, the shift register, the parity flop and the bit index.

## Test plan

- CLKS_PER_BIT=2, PARITY_EN=0, Din=8'hA5 held with DVALID:
  - SOUT sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 2 cycles;
  - DONE high exactly 20 cycles after the handshake edge;
  - BUSY high for 20 cycles.
- PARITY_EN=1, Din=8'h07:
  - parity bit = 1, frame length 11×CLKS_PER_BIT;
  - repeat with Din=8'h03: parity bit = 0.
- Back-to-back: DVALID held high with 8'h00 then 8'hFF:
  - second handshake occurs in the DONE cycle;
  - second start bit follows without an idle gap;
  - DREADY is low throughout both frames.
- Din changed to 8'h3C mid-frame while DVALID is high:
  - serialized data is unaffected;
  - the byte is accepted only when DREADY returns.
- RSTN pulled low during data bit 4:
  - next edge gives SOUT=1, BUSY=0, DONE=0, state IDLE;
  - no DONE pulse follows;
  - a new byte 8'h81 then transmits correctly.
- CLKS_PER_BIT=1, Din=8'h01:
  - SOUT sequence is 0,1,0,0,0,0,0,0,0,1, one cycle per bit;
  - DONE exactly 10 cycles after the handshake.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the framed PISO transmitter.
package piso_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int   DATA_BITS = 8;
  localparam logic SOUT_IDLE = 1'b1;
endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clr,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK) begin
    if (!RSTN)            cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
module piso_frame_tx
  import piso_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 DVALID,
  output logic                 DREADY,
  output logic                 SOUT,
  output logic                 BUSY,
  output logic                 DONE
);
  tx_state_t            state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par, par_nxt;
  logic [2:0]           bidx, bidx_nxt;
  logic                 sout_q, sout_nxt;
  logic                 done_q, done_nxt;
  logic                 tick;

  assign DREADY = RSTN && (state == IDLE);
  assign BUSY   = (state != IDLE);
  assign SOUT   = sout_q;
  assign DONE   = done_q;

  // Timer restarts on every state change so each bit gets a full period.
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (state_nxt != state),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    par_nxt   = par;
    bidx_nxt  = bidx;
    case (state)
      IDLE: if (DVALID && DREADY) begin
        shreg_nxt = Din;
        par_nxt   = PARITY_EN ? ^Din : 1'b0;
        state_nxt = START;
      end
      START:  if (tick) state_nxt = DATA;
      DATA: if (tick) begin
        shreg_nxt = shreg >> 1;
        bidx_nxt  = bidx + 3'd1;
        if (bidx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    done_nxt = (state == STOP) && tick;

    // Line level is registered from the next state so it changes on the same edge.
    sout_nxt = SOUT_IDLE;
    case (state_nxt)
      START:   sout_nxt = 1'b0;
      DATA:    sout_nxt = shreg_nxt[0];
      PARITY:  sout_nxt = par_nxt;
      default: sout_nxt = SOUT_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= IDLE;
      shreg  <= '0;
      par    <= 1'b0;
      bidx   <= '0;
      sout_q <= SOUT_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      par    <= par_nxt;
      bidx   <= bidx_nxt;
      sout_q <= sout_nxt;
      done_q <= done_nxt;
    end
  end
endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx across three parameter sets.
module tb_piso_frame_tx;
  localparam int NDUT = 3;
  localparam int CPB [NDUT] = '{2, 3, 1};
  localparam bit PEN [NDUT] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    logic [10:0] bits;  // transmitted order, first bit at [n-1]
    int          n;
  } exp_t;

  logic                 clk;
  logic [NDUT-1:0]      rstn, dv, dready, sout, busy, done;
  logic [7:0]           din [NDUT];

  exp_t q0[$], q1[$], q2[$];
  int   checks, errors;
  int   stim_to;
  bit   stim_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    piso_frame_tx #(.CLKS_PER_BIT(CPB[g]), .PARITY_EN(PEN[g])) u_dut (
      .CLK    (clk),
      .RSTN   (rstn[g]),
      .Din    (din[g]),
      .DVALID (dv[g]),
      .DREADY (dready[g]),
      .SOUT   (sout[g]),
      .BUSY   (busy[g]),
      .DONE   (done[g])
    );
  end

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Present a byte and hold it until the handshake edge; DVALID stays high afterwards.
  task automatic send(input int d, input logic [7:0] b, input logic [10:0] bits, input int n);
    exp_t e;
    bit   ok;
    e.bits = bits;
    e.n    = n;
    din[d] = b;
    dv[d]  = 1'b1;
    push(d, e);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dready[d]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      stim_to++;
      $display("FAIL handshake_timeout dut%0d dready=0 required=1", d);
      dv[d] = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstn = '0; dv = '0; stim_done = 1'b0; stim_to = 0;
    for (int i = 0; i < NDUT; i++) din[i] = 8'h00;
    repeat (3) @(posedge clk); #1;
    rstn = '1;
    @(posedge clk); #1;

    send(0, 8'hA5, 11'b0101001011, 10); dv[0] = 1'b0;
    repeat (25) @(posedge clk); #1;
    // back-to-back with DVALID held high
    send(0, 8'h00, 11'b0000000001, 10);
    send(0, 8'hFF, 11'b0111111111, 10);
    // Din changes mid-frame; 3C must wait for DREADY
    send(0, 8'h5A, 11'b0010110101, 10);
    send(0, 8'h3C, 11'b0001111001, 10); dv[0] = 1'b0;
    // abort during data bit 4, with DVALID raised in the reset cycle
    send(0, 8'hC3, 11'b0110000111, 10); dv[0] = 1'b0;
    repeat (10) @(posedge clk); #1;
    rstn[0] = 1'b0; din[0] = 8'h81; dv[0] = 1'b1;
    @(posedge clk); #1;
    rstn[0] = 1'b1;
    send(0, 8'h81, 11'b0100000011, 10); dv[0] = 1'b0;

    send(1, 8'h07, 11'b01110000011, 11); dv[1] = 1'b0;
    send(1, 8'h03, 11'b01100000001, 11); dv[1] = 1'b0;

    send(2, 8'h01, 11'b0100000001, 10); dv[2] = 1'b0;
    send(2, 8'hFF, 11'b0111111111, 10);
    send(2, 8'h00, 11'b0000000001, 10); dv[2] = 1'b0;

    repeat (40) @(posedge clk);
    stim_done = 1'b1;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, d, a, e, $time);
    end
  endtask

  bit   act [NDUT];
  bit   hs  [NDUT];
  bit   rp  [NDUT];
  int   j   [NDUT];
  exp_t cur [NDUT];
  int   cyc, qsz, k;
  bit   got;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    for (int d = 0; d < NDUT; d++) begin act[d] = 0; hs[d] = 0; rp[d] = 1; j[d] = 0; end
    while (!stim_done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
        if (rp[d]) begin
          chk("rst_sout", d, sout[d], 1);
          chk("rst_busy", d, busy[d], 0);
          chk("rst_done", d, done[d], 0);
          chk("rst_dready", d, dready[d], rstn[d]);
          act[d] = 0;
        end else begin
          if (hs[d]) begin
            got = 0;
            case (d)
              0:       if (q0.size() > 0) begin cur[d] = q0.pop_front(); got = 1; end
              1:       if (q1.size() > 0) begin cur[d] = q1.pop_front(); got = 1; end
              default: if (q2.size() > 0) begin cur[d] = q2.pop_front(); got = 1; end
            endcase
            chk("expected_frame", d, got, 1);
            act[d] = got;
            j[d] = 0;
          end else if (act[d]) begin
            j[d]++;
          end
          if (act[d]) begin
            if (j[d] < cur[d].n * CPB[d]) begin
              k = j[d] / CPB[d];
              chk("sout_bit", d, sout[d], cur[d].bits[cur[d].n - 1 - k]);
              chk("busy_frame", d, busy[d], 1);
              chk("done_early", d, done[d], 0);
              chk("dready_frame", d, dready[d], 0);
            end else begin
              chk("done_end", d, done[d], 1);
              chk("busy_end", d, busy[d], 0);
              chk("sout_end", d, sout[d], 1);
              chk("dready_end", d, dready[d], rstn[d]);
              act[d] = 0;
            end
          end else begin
            chk("idle_done", d, done[d], 0);
            chk("idle_busy", d, busy[d], 0);
            chk("idle_sout", d, sout[d], 1);
            chk("idle_dready", d, dready[d], rstn[d]);
          end
        end
        hs[d] = dv[d] && dready[d];
        rp[d] = !rstn[d];
      end
    end
    chk("stim_complete", 0, stim_done, 1);
    chk("stim_timeouts", 0, stim_to, 0);
    for (int d = 0; d < NDUT; d++) begin
      qsz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      chk("queue_empty", d, qsz, 0);
      chk("frame_closed", d, act[d], 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
